// File: rtl/display_pkg.sv
// ------------------------------------------------------------------
// display_pkg: shared constants, FSM encoding and helpers for the scan driver
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package display_pkg;

  localparam int         NUM_DIGITS_DEFAULT = 4;
  localparam logic [3:0] BLANK_CODE         = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_e;

  // Largest value that fits in the given number of decimal digits.
  function automatic int max_display(input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// ------------------------------------------------------------------
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    ovf_o
);

  localparam int               BCD_W     = 4 * NUM_DIGITS;
  localparam int               CNT_W     = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_BIN   = BIN_W'(max_display(NUM_DIGITS));
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  logic [BIN_W-1:0] shift_q;
  logic [BCD_W-1:0] acc_q;
  logic [BCD_W-1:0] adj_d;
  logic [CNT_W-1:0] iter_q;
  logic             active_q;
  logic             ovf_q;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    assign adj_d[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5) ? acc_q[4*g +: 4] + 4'd3
                                                        : acc_q[4*g +: 4];
  end

  // High during the final iteration, so the result is settled the cycle after.
  assign done_o = active_q && (iter_q == LAST_ITER);
  assign bcd_o  = acc_q;
  assign ovf_o  = ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      active_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (start_i) begin
      shift_q  <= bin_i;
      acc_q    <= '0;
      iter_q   <= '0;
      active_q <= 1'b1;
      ovf_q    <= (bin_i > MAX_BIN);
    end else if (active_q) begin
      acc_q   <= {adj_d[BCD_W-2:0], shift_q[BIN_W-1]};
      shift_q <= {shift_q[BIN_W-2:0], 1'b0};
      iter_q  <= iter_q + 1'b1;
      ovf_q   <= ovf_q | adj_d[BCD_W-1];
      if (done_o) active_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/display_scan_driver.sv
// ------------------------------------------------------------------
// display_scan_driver: load/convert FSM, display register and multiplexed digit scan
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module display_scan_driver
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
  parameter int BIN_W      = 14,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BIN_W-1:0]      bin_value,
  input  logic                  load,
  output logic                  busy,
  output logic                  ovf,
  output logic [3:0]            bcd,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int                    BCD_W      = 4 * NUM_DIGITS;
  localparam int                    IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int                    PRESC_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_RESET   = ~NUM_DIGITS'(1);

  state_e                  state_q;
  logic                    busy_q;
  logic                    ovf_q;
  logic [BCD_W-1:0]        disp_q;
  logic [PRESC_W-1:0]      presc_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [3:0]              bcd_q;

  logic                    conv_start;
  logic                    eng_done;
  logic                    eng_ovf;
  logic [BCD_W-1:0]        eng_bcd;
  logic                    tick;
  logic                    zero_above;
  logic [NUM_DIGITS-1:0]   blank_d;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [3:0]              bcd_d;

  assign conv_start = (state_q == IDLE) && load;

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .BIN_W      (BIN_W)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .bin_i   (bin_value),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd),
    .ovf_o   (eng_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (load) begin
          state_q <= CONVERT;
          busy_q  <= 1'b1;
        end
        CONVERT: if (eng_done) state_q <= COMMIT;
        COMMIT: begin
          ovf_q   <= eng_ovf;
          disp_q  <= eng_ovf ? {NUM_DIGITS{BLANK_CODE}} : eng_bcd;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A digit is blanked when it and everything above it is zero; digit 0 never is.
  always_comb begin
    zero_above = 1'b1;
    blank_d    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
      blank_d[i] = zero_above && (i != 0);
    end
  end

  always_comb begin
    an_d  = '1;
    bcd_d = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        an_d[i] = 1'b0;
        bcd_d   = blank_d[i] ? BLANK_CODE : disp_q[4*i +: 4];
      end
    end
  end

  assign tick = (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= AN_RESET;
      bcd_q   <= 4'h0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      an_q    <= an_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign bcd  = bcd_q;
  assign an   = an_q;

endmodule

`default_nettype wire
